// File: rtl/ps2_key_event_rx_pkg.sv
// Shared constants, types and key lookup for the PS/2 key event receiver.
// Scan codes are set 2; the ext flag marks keys that need the E0 prefix.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_ERR_LO = 8'h00;
  localparam logic [7:0] PS2_ERR_HI = 8'hFF;

  localparam logic [7:0] KEY_ESC_CODE   = 8'h76;
  localparam logic [7:0] KEY_S_CODE     = 8'h1B;
  localparam logic [7:0] KEY_R_CODE     = 8'h2D;
  localparam logic [7:0] KEY_UP_CODE    = 8'h75;
  localparam logic [7:0] KEY_DOWN_CODE  = 8'h72;
  localparam logic [7:0] KEY_RIGHT_CODE = 8'h74;
  localparam logic [7:0] KEY_LEFT_CODE  = 8'h6B;

  localparam logic KEY_ESC_EXT   = 1'b0;
  localparam logic KEY_S_EXT     = 1'b0;
  localparam logic KEY_R_EXT     = 1'b0;
  localparam logic KEY_UP_EXT    = 1'b1;
  localparam logic KEY_DOWN_EXT  = 1'b1;
  localparam logic KEY_RIGHT_EXT = 1'b1;
  localparam logic KEY_LEFT_EXT  = 1'b1;

  localparam logic [2:0] KEY_IDX_ESC   = 3'd0;
  localparam logic [2:0] KEY_IDX_S     = 3'd1;
  localparam logic [2:0] KEY_IDX_R     = 3'd2;
  localparam logic [2:0] KEY_IDX_UP    = 3'd3;
  localparam logic [2:0] KEY_IDX_DOWN  = 3'd4;
  localparam logic [2:0] KEY_IDX_RIGHT = 3'd5;
  localparam logic [2:0] KEY_IDX_LEFT  = 3'd6;

  localparam int EV_EXT     = 9;
  localparam int EV_BRK     = 8;
  localparam int EV_CODE_HI = 7;
  localparam int EV_CODE_LO = 0;
  localparam int EV_WIDTH   = 10;

  typedef enum logic {
    FR_IDLE,
    FR_RECV
  } frameState_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } keyMap_t;

  // Maps an (ext, code) pair onto its key_held bit; hit=0 for unmapped keys.
  function automatic keyMap_t keyLookup(input logic ext, input logic [7:0] code);
    keyMap_t m;
    m.hit = 1'b1;
    m.idx = 3'd0;
    case ({ext, code})
      {KEY_ESC_EXT, KEY_ESC_CODE}:     m.idx = KEY_IDX_ESC;
      {KEY_S_EXT, KEY_S_CODE}:         m.idx = KEY_IDX_S;
      {KEY_R_EXT, KEY_R_CODE}:         m.idx = KEY_IDX_R;
      {KEY_UP_EXT, KEY_UP_CODE}:       m.idx = KEY_IDX_UP;
      {KEY_DOWN_EXT, KEY_DOWN_CODE}:   m.idx = KEY_IDX_DOWN;
      {KEY_RIGHT_EXT, KEY_RIGHT_CODE}: m.idx = KEY_IDX_RIGHT;
      {KEY_LEFT_EXT, KEY_LEFT_CODE}:   m.idx = KEY_IDX_LEFT;
      default:                         m.hit = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_key_event_rx_if.sv
// Valid/ready key event stream between the receiver and its consumer.
interface ps2_key_event_rx_if;
  logic [9:0] ev_data;
  logic       ev_valid;
  logic       ev_ready;

  modport master (output ev_data, output ev_valid, input ev_ready);
  modport slave  (input ev_data, input ev_valid, output ev_ready);
endinterface

// File: rtl/ps2_key_event_rx_fifo.sv
// Show-ahead FIFO: o_data is registered so it reads as the head entry and
// keeps its last value once the FIFO drains.
module ps2_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_dout;

  logic          w_doPush;
  logic          w_doPop;
  logic [AW-1:0] w_rdNext;
  logic [AW:0]   w_cntNext;

  assign o_valid  = (r_count != '0);
  assign o_full   = (r_count == (AW+1)'(DEPTH));
  assign o_data   = r_dout;
  assign w_doPop  = i_pop & o_valid;
  assign w_doPush = i_push & (~o_full | w_doPop);
  assign w_rdNext = w_doPop ? r_rdPtr + AW'(1) : r_rdPtr;

  always_comb begin
    w_cntNext = r_count;
    if (w_doPush && !w_doPop) w_cntNext = r_count + (AW+1)'(1);
    else if (!w_doPush && w_doPop) w_cntNext = r_count - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_data;
  end

  // The new head bypasses the memory when the pushed word lands in the head slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_dout  <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
      r_rdPtr <= w_rdNext;
      r_count <= w_cntNext;
      if (w_cntNext != '0)
        r_dout <= (w_doPush && (r_wrPtr == w_rdNext)) ? i_data : r_mem[w_rdNext];
    end
  end

endmodule

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: synchronises and filters the PS/2 lines, frames and
// checks bytes, decodes E0/F0 prefixes into key events and tracks held keys.
module ps2_key_event_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               PS2_C,
  input  logic               PS2_D,
  ps2_key_event_rx_if.master evIf,
  output logic [6:0]         key_held,
  output logic               frame_err,
  output logic               overflow
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic r_rstMeta, r_rstSync;
  logic w_rst;

  logic       r_c1, r_c2, r_d1, r_d2;
  logic       r_filtC, r_filtDly;
  logic [7:0] r_filtCnt;
  logic       w_fall;

  frameState_t r_state;
  logic [3:0]  r_bitCount;
  logic [9:0]  r_shift;
  logic [TO_W-1:0] r_toCnt;
  logic        r_frameOk, r_frameBad, r_timeout;
  logic [7:0]  r_byte;
  logic [10:0] w_frame;
  logic        w_frameGood;

  logic          r_ext, r_brk;
  logic          r_push;
  logic [EV_WIDTH-1:0] r_pushData;
  logic [6:0]    r_keyHeld;
  logic          r_frameErr;
  logic          r_overflow;
  keyMap_t       w_key;
  logic [6:0]    w_keyMask;

  logic w_fifoFull;
  logic w_fifoValid;
  logic w_drop;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_rstMeta <= 1'b1;
      r_rstSync <= 1'b1;
    end else begin
      r_rstMeta <= 1'b0;
      r_rstSync <= r_rstMeta;
    end
  end
  assign w_rst = r_rstSync;

  always_ff @(posedge CLK or posedge w_rst) begin
    if (w_rst) begin
      r_c1      <= 1'b1;
      r_c2      <= 1'b1;
      r_d1      <= 1'b1;
      r_d2      <= 1'b1;
      r_filtC   <= 1'b1;
      r_filtDly <= 1'b1;
      r_filtCnt <= '0;
    end else begin
      r_c1      <= PS2_C;
      r_c2      <= r_c1;
      r_d1      <= PS2_D;
      r_d2      <= r_d1;
      r_filtDly <= r_filtC;
      if (r_c2 != r_filtC) begin
        if (r_filtCnt == 8'(FILTER_LEN - 1)) begin
          r_filtC   <= r_c2;
          r_filtCnt <= '0;
        end else begin
          r_filtCnt <= r_filtCnt + 8'd1;
        end
      end else begin
        r_filtCnt <= '0;
      end
    end
  end

  assign w_fall      = r_filtDly & ~r_filtC;
  assign w_frame     = {r_d2, r_shift};
  assign w_frameGood = ~w_frame[0] & (^w_frame[9:1]) & w_frame[10];

  // Frame FSM: the eleventh falling edge is checked straight from the live data bit.
  always_ff @(posedge CLK or posedge w_rst) begin
    if (w_rst) begin
      r_state    <= FR_IDLE;
      r_bitCount <= '0;
      r_shift    <= '0;
      r_toCnt    <= '0;
      r_frameOk  <= 1'b0;
      r_frameBad <= 1'b0;
      r_timeout  <= 1'b0;
      r_byte     <= '0;
    end else begin
      r_frameOk  <= 1'b0;
      r_frameBad <= 1'b0;
      r_timeout  <= 1'b0;
      case (r_state)
        FR_IDLE: begin
          r_toCnt <= '0;
          if (w_fall) begin
            r_shift    <= {r_d2, r_shift[9:1]};
            r_bitCount <= 4'd1;
            r_state    <= FR_RECV;
          end
        end
        FR_RECV: begin
          if (w_fall) begin
            r_toCnt <= '0;
            if (r_bitCount == 4'd10) begin
              r_bitCount <= '0;
              r_state    <= FR_IDLE;
              if (w_frameGood) begin
                r_frameOk <= 1'b1;
                r_byte    <= w_frame[8:1];
              end else begin
                r_frameBad <= 1'b1;
              end
            end else begin
              r_shift    <= {r_d2, r_shift[9:1]};
              r_bitCount <= r_bitCount + 4'd1;
            end
          end else if (r_toCnt == TO_W'(TIMEOUT_CYC - 1)) begin
            r_timeout  <= 1'b1;
            r_bitCount <= '0;
            r_toCnt    <= '0;
            r_state    <= FR_IDLE;
          end else begin
            r_toCnt <= r_toCnt + TO_W'(1);
          end
        end
        default: r_state <= FR_IDLE;
      endcase
    end
  end

  assign w_key     = keyLookup(r_ext, r_byte);
  assign w_keyMask = 7'(1) << w_key.idx;

  // Decoder: prefixes accumulate until a key byte consumes them.
  always_ff @(posedge CLK or posedge w_rst) begin
    if (w_rst) begin
      r_ext      <= 1'b0;
      r_brk      <= 1'b0;
      r_push     <= 1'b0;
      r_pushData <= '0;
      r_keyHeld  <= '0;
      r_frameErr <= 1'b0;
    end else begin
      r_push     <= 1'b0;
      r_frameErr <= 1'b0;
      if (r_frameBad || r_timeout) begin
        r_ext      <= 1'b0;
        r_brk      <= 1'b0;
        r_frameErr <= 1'b1;
      end else if (r_frameOk) begin
        case (r_byte)
          PS2_EXT: r_ext <= 1'b1;
          PS2_BRK: r_brk <= 1'b1;
          PS2_ERR_LO, PS2_ERR_HI: begin
            r_ext      <= 1'b0;
            r_brk      <= 1'b0;
            r_frameErr <= 1'b1;
          end
          default: begin
            r_push                           <= 1'b1;
            r_pushData[EV_EXT]               <= r_ext;
            r_pushData[EV_BRK]               <= r_brk;
            r_pushData[EV_CODE_HI:EV_CODE_LO] <= r_byte;
            if (w_key.hit)
              r_keyHeld <= r_brk ? (r_keyHeld & ~w_keyMask) : (r_keyHeld | w_keyMask);
            r_ext <= 1'b0;
            r_brk <= 1'b0;
          end
        endcase
      end
    end
  end

  ps2_event_fifo #(
    .WIDTH (EV_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (w_rst),
    .i_push  (r_push),
    .i_data  (r_pushData),
    .i_pop   (evIf.ev_ready),
    .o_data  (evIf.ev_data),
    .o_valid (w_fifoValid),
    .o_full  (w_fifoFull)
  );

  assign w_drop = r_push & w_fifoFull & ~(w_fifoValid & evIf.ev_ready);

  always_ff @(posedge CLK or posedge w_rst) begin
    if (w_rst) r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

  assign evIf.ev_valid = w_fifoValid;
  assign key_held      = r_keyHeld;
  assign frame_err     = r_frameErr;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Directed bench for ps2_key_event_rx: a table of single frames with expected
// event/held/error results, plus latency, timeout, overflow and reset sequences.
module tb_ps2_key_event_rx;

  localparam int FILT  = 4;
  localparam int TOUT  = 400;
  localparam int DEPTH = 8;
  localparam int HALF  = 10;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       PS2_C;
  logic       PS2_D;
  logic [6:0] key_held;
  logic       frame_err;
  logic       overflow;

  ps2_key_event_rx_if evIf();

  ps2_key_event_rx #(
    .FILTER_LEN  (FILT),
    .TIMEOUT_CYC (TOUT),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .PS2_C     (PS2_C),
    .PS2_D     (PS2_D),
    .evIf      (evIf),
    .key_held  (key_held),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 CLK = ~CLK;

  int nCompared   = 0;
  int nMismatched = 0;
  int errPulses   = 0;
  logic [9:0] gotQ[$];

  typedef struct {
    logic [7:0] code;
    logic       badPar;
    logic       expPush;
    logic [9:0] expEv;
    logic [6:0] expHeld;
    logic       expErr;
  } vec_t;
  vec_t vecs[$];

  // Count frame_err high cycles and log every popped event.
  always @(negedge CLK) begin
    if (frame_err === 1'b1) errPulses++;
  end

  always @(negedge CLK) begin
    #2;
    if (evIf.ev_valid === 1'b1 && evIf.ev_ready === 1'b1) gotQ.push_back(evIf.ev_data);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Clocks out the first nBits of a frame (11 = complete), then idles high.
  task automatic applyStimulus(input logic [7:0] code, input logic badPar, input int nBits);
    logic [10:0] fr;
    logic        par;
    par = ~(^code) ^ badPar;
    fr  = {1'b1, par, code, 1'b0};
    for (int i = 0; i < nBits; i++) begin
      PS2_D = fr[i];
      repeat (HALF) @(negedge CLK);
      PS2_C = 1'b0;
      repeat (HALF) @(negedge CLK);
      PS2_C = 1'b1;
    end
    PS2_D = 1'b1;
    repeat (2 * HALF) @(negedge CLK);
  endtask

  function automatic void addVec(input logic [7:0] code, input logic badPar, input logic expPush,
                                 input logic [9:0] expEv, input logic [6:0] expHeld, input logic expErr);
    vec_t v;
    v.code = code; v.badPar = badPar; v.expPush = expPush;
    v.expEv = expEv; v.expHeld = expHeld; v.expErr = expErr;
    vecs.push_back(v);
  endfunction

  task automatic sendAndExpect(input logic [7:0] code, input logic [9:0] expEv, input string name);
    int qB;
    qB = gotQ.size();
    applyStimulus(code, 1'b0, 11);
    checkOutput({name, ".count"}, gotQ.size() - qB, 1);
    if (gotQ.size() > qB) checkOutput({name, ".data"}, gotQ[qB], expEv);
  endtask

  initial begin
    int   qB;
    int   eB;
    logic heldAt7, heldAt8, validAt8, validAt9;

    addVec(8'h1B, 0, 1, 10'h01B, 7'h02, 0);
    addVec(8'hF0, 0, 0, 10'h000, 7'h02, 0);
    addVec(8'h1B, 0, 1, 10'h11B, 7'h00, 0);
    addVec(8'hE0, 0, 0, 10'h000, 7'h00, 0);
    addVec(8'h75, 0, 1, 10'h275, 7'h08, 0);
    addVec(8'h75, 0, 1, 10'h075, 7'h08, 0);
    addVec(8'hE0, 0, 0, 10'h000, 7'h08, 0);
    addVec(8'hF0, 0, 0, 10'h000, 7'h08, 0);
    addVec(8'h75, 0, 1, 10'h375, 7'h00, 0);
    addVec(8'h76, 1, 0, 10'h000, 7'h00, 1);
    addVec(8'h76, 0, 1, 10'h076, 7'h01, 0);
    addVec(8'hF0, 0, 0, 10'h000, 7'h01, 0);
    addVec(8'h76, 0, 1, 10'h176, 7'h00, 0);
    addVec(8'h00, 0, 0, 10'h000, 7'h00, 1);
    addVec(8'hFF, 0, 0, 10'h000, 7'h00, 1);
    addVec(8'hE0, 0, 0, 10'h000, 7'h00, 0);
    addVec(8'h00, 0, 0, 10'h000, 7'h00, 1);
    addVec(8'h74, 0, 1, 10'h074, 7'h00, 0);
    addVec(8'hE0, 0, 0, 10'h000, 7'h00, 0);
    addVec(8'h6B, 1, 0, 10'h000, 7'h00, 1);
    addVec(8'h6B, 0, 1, 10'h06B, 7'h00, 0);
    addVec(8'hE0, 0, 0, 10'h000, 7'h00, 0);
    addVec(8'h6B, 0, 1, 10'h26B, 7'h40, 0);
    addVec(8'hE0, 0, 0, 10'h000, 7'h40, 0);
    addVec(8'h72, 0, 1, 10'h272, 7'h50, 0);
    addVec(8'h2D, 0, 1, 10'h02D, 7'h54, 0);
    addVec(8'hE0, 0, 0, 10'h000, 7'h54, 0);
    addVec(8'hF0, 0, 0, 10'h000, 7'h54, 0);
    addVec(8'h6B, 0, 1, 10'h36B, 7'h14, 0);
    addVec(8'hE0, 0, 0, 10'h000, 7'h14, 0);
    addVec(8'hF0, 0, 0, 10'h000, 7'h14, 0);
    addVec(8'h72, 0, 1, 10'h372, 7'h04, 0);
    addVec(8'hF0, 0, 0, 10'h000, 7'h04, 0);
    addVec(8'h2D, 0, 1, 10'h12D, 7'h00, 0);
    addVec(8'hE0, 0, 0, 10'h000, 7'h00, 0);
    addVec(8'h74, 0, 1, 10'h274, 7'h20, 0);
    addVec(8'hE0, 0, 0, 10'h000, 7'h20, 0);
    addVec(8'hF0, 0, 0, 10'h000, 7'h20, 0);
    addVec(8'h74, 0, 1, 10'h374, 7'h00, 0);

    RESET = 1'b1;
    PS2_C = 1'b1;
    PS2_D = 1'b1;
    evIf.ev_ready = 1'b0;
    repeat (4) @(negedge CLK);
    checkOutput("rst.ev_valid", evIf.ev_valid, 0);
    checkOutput("rst.ev_data", evIf.ev_data, 0);
    checkOutput("rst.key_held", key_held, 0);
    checkOutput("rst.frame_err", frame_err, 0);
    checkOutput("rst.overflow", overflow, 0);
    RESET = 1'b0;
    repeat (5) @(negedge CLK);

    // Latency: raw stop-bit drop, +2 sync, +FILT-1 filter, then N+2 held, N+3 valid.
    $display("[TB] latency sequence");
    applyStimulus(8'h1B, 1'b0, 10);
    PS2_D = 1'b1;
    repeat (HALF) @(negedge CLK);
    PS2_C = 1'b0;
    heldAt7 = 1'b0; heldAt8 = 1'b0; validAt8 = 1'b0; validAt9 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      if (k == 7) heldAt7 = key_held[1];
      if (k == 8) begin heldAt8 = key_held[1]; validAt8 = evIf.ev_valid; end
      if (k == 9) validAt9 = evIf.ev_valid;
      if (k == HALF) PS2_C = 1'b1;
    end
    repeat (2 * HALF) @(negedge CLK);
    checkOutput("lat.heldBefore", heldAt7, 0);
    checkOutput("lat.heldAt", heldAt8, 1);
    checkOutput("lat.validBefore", validAt8, 0);
    checkOutput("lat.validAt", validAt9, 1);
    checkOutput("lat.headData", evIf.ev_data, 10'h01B);
    evIf.ev_ready = 1'b1;
    repeat (4) @(negedge CLK);
    checkOutput("lat.popCount", gotQ.size(), 1);
    if (gotQ.size() > 0) checkOutput("lat.popData", gotQ[0], 10'h01B);

    $display("[TB] vector table, %0d entries", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      qB = gotQ.size();
      eB = errPulses;
      applyStimulus(vecs[i].code, vecs[i].badPar, 11);
      checkOutput($sformatf("vec%0d.held", i), key_held, vecs[i].expHeld);
      checkOutput($sformatf("vec%0d.evCount", i), gotQ.size() - qB, vecs[i].expPush);
      if (vecs[i].expPush && gotQ.size() > qB)
        checkOutput($sformatf("vec%0d.evData", i), gotQ[qB], vecs[i].expEv);
      checkOutput($sformatf("vec%0d.errPulses", i), errPulses - eB, vecs[i].expErr);
    end

    $display("[TB] timeout sequence");
    qB = gotQ.size();
    eB = errPulses;
    applyStimulus(8'h2D, 1'b0, 5);
    repeat (TOUT + 1) @(negedge CLK);
    checkOutput("to.errPulses", errPulses - eB, 1);
    checkOutput("to.noEvent", gotQ.size() - qB, 0);
    sendAndExpect(8'h2D, 10'h02D, "to.next");
    checkOutput("to.held", key_held, 7'h04);

    $display("[TB] overflow sequence");
    @(negedge CLK);
    evIf.ev_ready = 1'b0;
    qB = gotQ.size();
    applyStimulus(8'h15, 1'b0, 11);
    applyStimulus(8'h1C, 1'b0, 11);
    applyStimulus(8'h1B, 1'b0, 11);
    applyStimulus(8'h2D, 1'b0, 11);
    applyStimulus(8'h76, 1'b0, 11);
    applyStimulus(8'hE0, 1'b0, 11);
    applyStimulus(8'h75, 1'b0, 11);
    applyStimulus(8'hE0, 1'b0, 11);
    applyStimulus(8'h72, 1'b0, 11);
    applyStimulus(8'hE0, 1'b0, 11);
    applyStimulus(8'h74, 1'b0, 11);
    checkOutput("ovf.before", overflow, 0);
    applyStimulus(8'hE0, 1'b0, 11);
    applyStimulus(8'h6B, 1'b0, 11);
    checkOutput("ovf.after", overflow, 1);
    checkOutput("ovf.valid", evIf.ev_valid, 1);
    checkOutput("ovf.held", key_held, 7'h7F);
    checkOutput("ovf.head", evIf.ev_data, 10'h015);
    evIf.ev_ready = 1'b1;
    repeat (20) @(negedge CLK);
    checkOutput("ovf.drainCount", gotQ.size() - qB, 8);
    if (gotQ.size() - qB == 8) begin
      logic [9:0] expOrder [8];
      expOrder = '{10'h015, 10'h01C, 10'h01B, 10'h02D, 10'h076, 10'h275, 10'h272, 10'h274};
      for (int i = 0; i < 8; i++)
        checkOutput($sformatf("ovf.drain%0d", i), gotQ[qB + i], expOrder[i]);
    end
    checkOutput("ovf.emptyAfter", evIf.ev_valid, 0);
    checkOutput("ovf.sticky", overflow, 1);
    checkOutput("ovf.dataHeld", evIf.ev_data, 10'h274);

    $display("[TB] reset mid-frame sequence");
    applyStimulus(8'hE0, 1'b0, 11);
    applyStimulus(8'h74, 1'b0, 4);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    checkOutput("mrst.ev_valid", evIf.ev_valid, 0);
    checkOutput("mrst.ev_data", evIf.ev_data, 0);
    checkOutput("mrst.key_held", key_held, 0);
    checkOutput("mrst.overflow", overflow, 0);
    checkOutput("mrst.frame_err", frame_err, 0);
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    repeat (5) @(negedge CLK);
    sendAndExpect(8'h74, 10'h074, "mrst.next");
    checkOutput("mrst.heldAfter", key_held, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_rx.md
Name: ps2_key_event_rx

Overview:
Receives PS/2 keyboard frames in the system clock domain and validates start, odd parity and stop bits. Decodes the E0 (extended) and F0 (break) prefixes into make/break key events and buffers them in a valid/ready FIFO. It also keeps a live held-state bitmap of the seven game keys, so game logic can poll key state and consume key events without handling raw scan codes.

Parameters:
FILTER_LEN, 8, consecutive equal synchronized samples required before filtered PS2_C changes (1..255)
TIMEOUT_CYC, 100000, idle CLK cycles mid-frame before abort (2 ms at 50 MHz)
FIFO_DEPTH, 8, event FIFO entries; power of 2, >=2

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
PS2_C  in  1  raw PS/2 clock from connector
PS2_D  in  1  raw PS/2 data from connector
ev_data  out  10  {ext, brk, code[7:0]} at FIFO head
ev_valid  out  1  FIFO non-empty
ev_ready  in  1  consumer pop; a pop occurs when ev_valid && ev_ready
key_held  out  7  [0]esc [1]s [2]r [3]up [4]down [5]right [6]left
frame_err  out  1  one-cycle pulse on a discarded frame or byte
overflow  out  1  sticky; set when an event is dropped because the FIFO is full

Behaviour:
- Reset (async assert, sync deassert inside the block): ev_data=0, ev_valid=0, key_held=0, frame_err=0, overflow=0, FIFO empty, bit count=0, prefix flags cleared, filtered clock=1.
- Input conditioning: PS2_C and PS2_D each pass through a 2-flop synchronizer. The filtered clock toggles only after FILTER_LEN consecutive samples differ from its current value.
- A falling edge is a filtered 1->0 transition. On that cycle, sample synchronized PS2_D into the frame shift register.
- Frame layout is 11 bits: start(0), D0..D7 LSB first, parity, stop(1). The bit count runs 0..10 and wraps to 0 after the stop bit.
- Frame check, evaluated at the stop bit:
  - The frame is valid when start=0, the XOR of the data and parity bits is 1, and stop=1.
  - On failure: discard the byte, clear both prefix flags, and pulse frame_err.
- Timeout: if the bit count is nonzero and TIMEOUT_CYC cycles pass without a falling edge, reset the bit count to 0, clear the prefix flags, and pulse frame_err. The counter restarts on every falling edge.
- Decoder, one valid byte per frame:
  - 0xE0: set ext.
  - 0xF0: set brk.
  - 0x00 or 0xFF: keyboard error code. Drop it, clear the flags, pulse frame_err.
  - Any other byte: push {ext, brk, byte}, update key_held, then clear ext and brk.
- key_held mapping:
  - Unextended keys: esc=0x76, s=0x1B, r=0x2D.
  - Extended keys: up=E0 75, down=E0 72, right=E0 74, left=E0 6B.
  - A make sets the bit and a break clears it. Unmapped codes leave key_held unchanged.
  - key_held updates even when the push is dropped.
- Latency: let the filtered falling edge of the stop bit be cycle N. The frame check is registered at N+1. The push and the key_held update are visible at N+2. ev_valid rises at N+3 if the FIFO was empty.
- FIFO behaviour:
  - Show-ahead: ev_data is the head entry while ev_valid=1 and holds its last value when the FIFO is empty.
  - Push while full with no pop: drop the event and set overflow, which stays set until RESET.
  - Push and pop in the same cycle while full: both happen and the occupancy is unchanged.
  - Pop while empty: ignored.
- A RESET mid-frame or mid-prefix discards all partial state. No event is emitted for the interrupted frame.

Decomposition:
- Package ps2_pkg holds:
  - prefix constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0;
  - the error codes 8'h00 and 8'hFF;
  - the seven key scan codes and their ext flags;
  - key_held index constants;
  - the event field offsets EV_EXT=9, EV_BRK=8, EV_CODE=7:0.
- Sub-module ps2_event_fifo is a parametrised synchronous show-ahead FIFO (WIDTH, DEPTH) with full/empty, push and pop. It holds the buffering; the top module holds sync/filter, frame FSM, timeout and decoder.

Test Plan:
- Valid frame 0x1B, then F0 1B, FIFO drained -> events 0x01B then 0x11B. key_held[1] is 1 between the two events and 0 after. ev_valid rises 3 cycles after the stop-bit falling edge.
- Sequence E0 75, then E0 F0 75 -> events 0x275 then 0x375. key_held[3] goes 1 then 0. An unextended 0x75 leaves key_held unchanged and emits 0x075.
- Frame 0x76 with even parity -> frame_err pulses once, no event, key_held[0] stays 0. The next valid frame 0x76 yields 0x076.
- 5 bits clocked, then idle for TIMEOUT_CYC+1 cycles -> frame_err pulses once and the bit count returns to 0. A following full frame 0x2D decodes to 0x02D.
- FIFO_DEPTH=8, ev_ready=0, 9 make codes -> 8 events held, overflow=1, and key_held still reflects the 9th key. Then ev_ready=1 -> the first 8 events drain in order.
- RESET asserted mid-frame after an E0 prefix -> all outputs 0 immediately. A post-reset 0x74 yields 0x074 (ext not set).
